sv_req_target: RTL and testbench

- Downstream consumer of the request master's addr/valid/data/wen/ren bus.
- Drives `ready` back to the master.
- Buffers accepted requests in a small FIFO and executes them against an internal 64-bit word memory.
- Returns tagged read responses on a ready/valid response channel.

---
 rtl/sv_req_target.sv | 246 ++++++++++++++++++++++++
 tb/tb_sv_req_target.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_req_target.sv
// Request-bus target: queues addr/tag/data/wen requests in a FIFO and executes them in
// order against a 64-bit word memory, returning tagged responses. Optional: SV_REQ_TARGET_WRRESP_EN.
module sv_req_target #(
   parameter int  PARAM      = 8,
   parameter int  FIFO_DEPTH = 4,
   parameter int  MEM_DEPTH  = 256,
   parameter int  READ_LAT   = 2,
   localparam int TAG_W      = (PARAM > 1) ? $clog2(PARAM) : 1,
   localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic [TAG_W-1:0]  valid,
   input  logic [63:0]       data,
   input  logic              wen,
   input  logic              ren,
   output logic              ready,
   output logic [63:0]       rdata,
   output logic [TAG_W-1:0]  rtag,
   output logic              rvalid,
   input  logic              rready,
   output logic              err
);

   localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       RD_LOAD  = 4'(READ_LAT - 1);

   typedef struct packed {
      logic [31:0]      addr;
      logic [TAG_W-1:0] tag;
      logic [63:0]      data;
      logic             wr;
   } req_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } state_t;

   // Misaligned byte address or bits above the memory window both fault.
   function automatic logic addr_fault(input logic [31:0] a);
      return (a[2:0] != 3'd0) || ((a >> (3 + IDX_W)) != 32'd0);
   endfunction

   function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] a);
      return a[3+IDX_W-1:3];
   endfunction

   req_t             fifo_r [FIFO_DEPTH];
   logic [63:0]      mem_r  [MEM_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             ready_r;

   state_t           state_r;
   state_t           state_s;
   logic [3:0]       cnt_r;
   logic [3:0]       cnt_s;
   logic             load_s;
   logic             resp_set_s;
   logic             resp_clr_s;

   logic [TAG_W-1:0] pend_tag_r;
   logic [IDX_W-1:0] pend_idx_r;
   logic             pend_fault_r;
   logic             pend_wr_r;
   logic [63:0]      pend_data_r;

   logic             rvalid_r;
   logic [63:0]      rdata_r;
   logic [TAG_W-1:0] rtag_r;
   logic             err_r;

   req_t             req_in_s;
   req_t             head_s;
   logic             push_s;
   logic             drop_s;
   logic             pop_s;
   logic             empty_s;
   logic             issue_ok_s;
   logic             head_fault_s;
   logic [IDX_W-1:0] head_idx_s;
   logic             mem_we_s;
   logic [63:0]      resp_data_s;

   // Request acceptance, FIFO head decode and pop qualification.
   always_comb begin
      req_in_s.addr = addr;
      req_in_s.tag  = valid;
      req_in_s.data = data;
      req_in_s.wr   = wen;
      push_s        = (wen ^ ren) && ready_r;
      drop_s        = wen && ren && ready_r;
      head_s        = fifo_r[rd_ptr_r];
      empty_s       = (count_r == {CNT_W{1'b0}});
      issue_ok_s    = (state_r == ST_IDLE) || ((state_r == ST_RESP) && rready);
      pop_s         = !empty_s && issue_ok_s;
      head_fault_s  = addr_fault(head_s.addr);
      head_idx_s    = addr_index(head_s.addr);
      mem_we_s      = pop_s && head_s.wr && !head_fault_s;
   end

   // Occupancy after this edge's push/pop; ready follows it so a pop frees a slot next cycle.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Next-state, latency counter and response control; a pop may launch from IDLE or a completing RESP.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      load_s     = 1'b0;
      resp_set_s = 1'b0;
      resp_clr_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            state_s = ST_IDLE;
         end
         ST_RD_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s    = ST_RESP;
               resp_set_s = 1'b1;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            if (rready) begin
               state_s    = ST_IDLE;
               resp_clr_s = 1'b1;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      if (pop_s) begin
         if (!head_s.wr) begin
            state_s = ST_RD_WAIT;
            cnt_s   = RD_LOAD;
            load_s  = 1'b1;
         end else begin
`ifdef SV_REQ_TARGET_WRRESP_EN
            state_s = ST_RD_WAIT;
            cnt_s   = 4'd0;
            load_s  = 1'b1;
`else
            state_s = ST_IDLE;
`endif
         end
      end else begin
         load_s = load_s;
      end
   end

   // Response payload: faults read as zero, write responses echo the written data.
   always_comb begin
      if (pend_fault_r) begin
         resp_data_s = 64'd0;
      end else if (pend_wr_r) begin
         resp_data_s = pend_data_r;
      end else begin
         resp_data_s = mem_r[pend_idx_r];
      end
   end

   // FIFO entry storage; entries are only ever read while counted as valid.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         fifo_r[wr_ptr_r] <= req_in_s;
      end
   end

   // Word memory; deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (mem_we_s && !reset) begin
         mem_r[head_idx_s] <= head_s.data;
      end
   end

   // Control state, FIFO pointers, pending request and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r     <= {PTR_W{1'b0}};
         rd_ptr_r     <= {PTR_W{1'b0}};
         count_r      <= {CNT_W{1'b0}};
         ready_r      <= 1'b0;
         state_r      <= ST_IDLE;
         cnt_r        <= 4'd0;
         pend_tag_r   <= {TAG_W{1'b0}};
         pend_idx_r   <= {IDX_W{1'b0}};
         pend_fault_r <= 1'b0;
         pend_wr_r    <= 1'b0;
         pend_data_r  <= 64'd0;
         rvalid_r     <= 1'b0;
         rdata_r      <= 64'd0;
         rtag_r       <= {TAG_W{1'b0}};
         err_r        <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
         ready_r <= (count_nxt_s != FULL_CNT);
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (load_s) begin
            pend_tag_r   <= head_s.tag;
            pend_idx_r   <= head_idx_s;
            pend_fault_r <= head_fault_s;
            pend_wr_r    <= head_s.wr;
            pend_data_r  <= head_s.data;
         end
         if (resp_set_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= resp_data_s;
            rtag_r   <= pend_tag_r;
         end else if (resp_clr_s) begin
            rvalid_r <= 1'b0;
         end
         err_r <= drop_s || (pop_s && head_fault_s);
      end
   end

   assign ready  = ready_r;
   assign rvalid = rvalid_r;
   assign rdata  = rdata_r;
   assign rtag   = rtag_r;
   assign err    = err_r;

endmodule

// File: tb/tb_sv_req_target.sv
// Self-checking bench for sv_req_target: directed vector table, multi-cycle sequences and
// randomized traffic against an in-order request/response model.
module tb_sv_req_target;

`ifdef SV_REQ_TARGET_WRRESP_EN
   localparam bit WRR = 1'b1;
`else
   localparam bit WRR = 1'b0;
`endif
   localparam int READ_LAT = 2;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [2:0]  valid;
   logic [63:0] data;
   logic        wen;
   logic        ren;
   logic        ready;
   logic [63:0] rdata;
   logic [2:0]  rtag;
   logic        rvalid;
   logic        rready;
   logic        err;

   sv_req_target #(.PARAM(8), .FIFO_DEPTH(4), .MEM_DEPTH(256), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .reset(reset), .addr(addr), .valid(valid), .data(data),
      .wen(wen), .ren(ren), .ready(ready), .rdata(rdata), .rtag(rtag),
      .rvalid(rvalid), .rready(rready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  tag;
      logic [63:0] data;
      logic        wen;
      logic        ren;
      int          nresp;
      logic [63:0] edata;
      logic [2:0]  etag;
      int          eerr;
      int          elat;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  tag;
   } resp_t;

   typedef struct {
      logic [63:0] data;
      logic [2:0]  tag;
      bit          known;
   } exp_t;

   vec_t        tv[$];
   resp_t       got_q[$];
   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   int          err_seen = 0;
   int          first_rv = -1;
   logic [63:0] mem_m [8];
   bit          known_m [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      if (rvalid === 1'b1 && rready === 1'b1) got_q.push_back('{rdata, rtag});
      @(posedge clk);
      #1;
      cyc++;
      if (err === 1'b1) err_seen++;
      if (rvalid === 1'b1 && first_rv < 0) first_rv = cyc;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      if (ready !== 1'b1) chk("ready_timeout", 64'(ready), 64'd1);
   endtask

   task automatic send(input logic [31:0] a, input logic [2:0] t, input logic [63:0] d,
                       input logic w, input logic r);
      wait_ready();
      addr = a; valid = t; data = d; wen = w; ren = r;
      cycle();
      wen = 1'b0; ren = 1'b0;
   endtask

   task automatic compare_resps(input string nm);
      chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk({nm, "_tag"}, 64'(got_q[i].tag), 64'(exp_q[i].tag));
         if (exp_q[i].known) chk({nm, "_data"}, got_q[i].data, exp_q[i].data);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int exp_err;
      reset = 1'b1; addr = 32'd0; valid = 3'd0; data = 64'd0;
      wen = 1'b0; ren = 1'b0; rready = 1'b0;
      repeat (2) cycle();
      chk("reset_rvalid", 64'(rvalid), 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_rtag", 64'(rtag), 64'd0);
      chk("reset_err", 64'(err), 64'd0);
      chk("reset_ready", 64'(ready), 64'd0);
      reset = 1'b0;
      cycle();
      chk("ready_after_reset", 64'(ready), 64'd1);

      // Directed vectors: one request each; latency counts accept edge, pop edge, then the wait.
      tv.push_back('{32'h10,  3'd3, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, int'(WRR), 64'hDEADBEEF_CAFEF00D, 3'd3, 0, 3});
      tv.push_back('{32'h10,  3'd5, 64'h0, 1'b0, 1'b1, 1, 64'hDEADBEEF_CAFEF00D, 3'd5, 0, READ_LAT + 2});
      tv.push_back('{32'h0,   3'd0, 64'h0, 1'b1, 1'b1, 0, 64'h0, 3'd0, 1, 0});
      tv.push_back('{32'h804, 3'd6, 64'h0, 1'b0, 1'b1, 1, 64'h0, 3'd6, 1, READ_LAT + 2});
      tv.push_back('{32'h1000, 3'd7, 64'h0, 1'b0, 1'b1, 1, 64'h0, 3'd7, 1, READ_LAT + 2});
      tv.push_back('{32'h8,   3'd1, 64'h1234, 1'b1, 1'b0, int'(WRR), 64'h1234, 3'd1, 0, 3});
      tv.push_back('{32'h8,   3'd2, 64'h0, 1'b0, 1'b1, 1, 64'h1234, 3'd2, 0, READ_LAT + 2});
      tv.push_back('{32'h7F8, 3'd0, 64'hA5A5_0F0F_5A5A_F0F0, 1'b1, 1'b0, int'(WRR), 64'hA5A5_0F0F_5A5A_F0F0, 3'd0, 0, 3});
      tv.push_back('{32'h7F8, 3'd4, 64'h0, 1'b0, 1'b1, 1, 64'hA5A5_0F0F_5A5A_F0F0, 3'd4, 0, READ_LAT + 2});
      tv.push_back('{32'h0,   3'd0, 64'h5555, 1'b1, 1'b0, int'(WRR), 64'h5555, 3'd0, 0, 3});
      tv.push_back('{32'h803, 3'd2, 64'hFFFF, 1'b1, 1'b0, int'(WRR), 64'h0, 3'd2, 1, 3});
      tv.push_back('{32'h800, 3'd3, 64'h0, 1'b0, 1'b1, 1, 64'h0, 3'd3, 1, READ_LAT + 2});
      tv.push_back('{32'h0,   3'd5, 64'h0, 1'b0, 1'b1, 1, 64'h5555, 3'd5, 0, READ_LAT + 2});

      rready = 1'b1;
      for (int i = 0; i < tv.size(); i++) begin
         wait_ready();
         got_q.delete();
         err_seen = 0;
         first_rv = -1;
         start = cyc;
         addr = tv[i].addr; valid = tv[i].tag; data = tv[i].data;
         wen = tv[i].wen; ren = tv[i].ren;
         cycle();
         wen = 1'b0; ren = 1'b0;
         repeat (12) cycle();
         chk($sformatf("v%0d_nresp", i), 64'(got_q.size()), 64'(tv[i].nresp));
         chk($sformatf("v%0d_err", i), 64'(err_seen), 64'(tv[i].eerr));
         if (tv[i].nresp > 0 && got_q.size() > 0) begin
            chk($sformatf("v%0d_rdata", i), got_q[0].data, tv[i].edata);
            chk($sformatf("v%0d_rtag", i), 64'(got_q[0].tag), 64'(tv[i].etag));
            chk($sformatf("v%0d_lat", i), 64'(first_rv - start), 64'(tv[i].elat));
         end else begin
            chk($sformatf("v%0d_no_rvalid", i), 64'(first_rv), 64'(-1));
         end
      end

      // Backpressure: response held while 4 writes fill the FIFO.
      got_q.delete(); exp_q.delete(); err_seen = 0;
      rready = 1'b0;
      send(32'h10, 3'd4, 64'h0, 1'b0, 1'b1);
      exp_q.push_back('{64'hDEADBEEF_CAFEF00D, 3'd4, 1'b1});
      for (int j = 0; j < 4; j++) begin
         send(32'h20 + 32'(8 * j), 3'(j), 64'h1000 + 64'(j), 1'b1, 1'b0);
         if (WRR) exp_q.push_back('{64'h1000 + 64'(j), 3'(j), 1'b1});
      end
      chk("bp_ready_low", 64'(ready), 64'd0);
      repeat (3) cycle();
      chk("bp_ready_still_low", 64'(ready), 64'd0);
      chk("bp_rvalid_hold", 64'(rvalid), 64'd1);
      chk("bp_rdata_hold", rdata, 64'hDEADBEEF_CAFEF00D);
      rready = 1'b1;
      begin
         int n = 0;
         while (ready !== 1'b1 && n < 30) begin
            cycle();
            n++;
         end
      end
      chk("bp_ready_reassert", 64'(ready), 64'd1);
      for (int j = 0; j < 4; j++) begin
         send(32'h20 + 32'(8 * j), 3'(j + 4), 64'h0, 1'b0, 1'b1);
         exp_q.push_back('{64'h1000 + 64'(j), 3'(j + 4), 1'b1});
      end
      repeat (30) cycle();
      compare_resps("bp");
      chk("bp_err", 64'(err_seen), 64'd0);

      // Reset while a read waits and two requests are queued.
      got_q.delete(); err_seen = 0;
      send(32'h10, 3'd0, 64'h0, 1'b0, 1'b1);
      send(32'h10, 3'd1, 64'h1111, 1'b1, 1'b0);
      send(32'h10, 3'd6, 64'h0, 1'b0, 1'b1);
      chk("pre_reset_rvalid", 64'(rvalid), 64'd0);
      reset = 1'b1;
      cycle();
      chk("mid_reset_rvalid", 64'(rvalid), 64'd0);
      chk("mid_reset_ready", 64'(ready), 64'd0);
      reset = 1'b0;
      repeat (15) cycle();
      chk("post_reset_no_resp", 64'(got_q.size()), 64'd0);
      chk("post_reset_err", 64'(err_seen), 64'd0);
      chk("post_reset_ready", 64'(ready), 64'd1);
      got_q.delete(); exp_q.delete();
      send(32'h10, 3'd2, 64'h0, 1'b0, 1'b1);
      exp_q.push_back('{64'hDEADBEEF_CAFEF00D, 3'd2, 1'b1});
      repeat (12) cycle();
      compare_resps("post_reset");

      // Random traffic: expected responses follow strict request order over model memory.
      got_q.delete(); exp_q.delete(); err_seen = 0; exp_err = 0;
      for (int k = 0; k < 8; k++) known_m[k] = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rready = ($urandom_range(3) != 0);
         if ($urandom_range(1) == 1) begin
            int op;
            int idx;
            logic [2:0]  t;
            logic [63:0] d;
            op  = $urandom_range(9);
            idx = $urandom_range(7);
            t   = 3'($urandom_range(7));
            d   = {$urandom(), $urandom()};
            addr = 32'(idx * 8); valid = t; data = d;
            wen = (op == 0) || (op >= 5);
            ren = (op <= 4);
            if (ready === 1'b1) begin
               if (op == 0) begin
                  exp_err++;
               end else if (op >= 5) begin
                  mem_m[idx]   = d;
                  known_m[idx] = 1'b1;
                  if (WRR) exp_q.push_back('{d, t, 1'b1});
               end else begin
                  exp_q.push_back('{mem_m[idx], t, known_m[idx]});
               end
            end
         end else begin
            wen = 1'b0; ren = 1'b0;
         end
         cycle();
      end
      wen = 1'b0; ren = 1'b0; rready = 1'b1;
      begin
         int n = 0;
         while (got_q.size() < exp_q.size() && n < 300) begin
            cycle();
            n++;
         end
      end
      repeat (10) cycle();
      compare_resps("rand");
      chk("rand_err", 64'(err_seen), 64'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
